// File: rtl/execute_stage_if.sv
// ID/EX operand bundle into the EX stage and the EX/MEM register contents out of it.
// The bench drives through master; the execute stage connects as slave.
interface execute_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
);
  logic            StallM;
  logic            FlushM;
  logic            ValidE;
  logic            RegWriteE;
  logic            MemWriteE;
  logic [1:0]      ResultSrcE;
  logic            BranchE;
  logic            JumpE;
  logic            JalrE;
  logic            ALUSrcE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] RD1_E;
  logic [XLEN-1:0] RD2_E;
  logic [XLEN-1:0] Imm_Ext_E;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [REGW-1:0] RD_E;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ResultW;

  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            RegWriteM;
  logic            MemWriteM;
  logic            ValidM;
  logic [1:0]      ResultSrcM;
  logic [REGW-1:0] RD_M;
  logic [XLEN-1:0] ALU_ResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCPlus4M;

  modport master (
    output StallM, FlushM, ValidE, RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE,
           JalrE, ALUSrcE, ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
           ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ValidM, ResultSrcM, RD_M,
           ALU_ResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  StallM, FlushM, ValidE, RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE,
           JalrE, ALUSrcE, ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
           ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ValidM, ResultSrcM, RD_M,
           ALU_ResultM, WriteDataM, PCPlus4M
  );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, beq/jal/jalr resolution and the EX/MEM register.
// Redirect outputs are combinational; everything bound for MEM is registered.
module execute_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input logic          clk,
  input logic          rst,
  execute_stage_if.slave ex
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] jalr_sum;
  logic [SHW-1:0]  shamt;
  logic            zero;
  logic            slt;

  // Select 10 feeds back this stage's own registered result, held value included while stalled.
  always_comb begin
    src_a = ex.RD1_E;
    case (ex.ForwardAE)
      2'b01:   src_a = ex.ResultW;
      2'b10:   src_a = ex.ALU_ResultM;
      default: src_a = ex.RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = ex.RD2_E;
    case (ex.ForwardBE)
      2'b01:   fwd_b = ex.ResultW;
      2'b10:   fwd_b = ex.ALU_ResultM;
      default: fwd_b = ex.RD2_E;
    endcase
  end

  assign src_b = ex.ALUSrcE ? ex.Imm_Ext_E : fwd_b;
  assign sum   = src_a + src_b;
  assign diff  = src_a - src_b;
  assign shamt = src_b[SHW-1:0];
  assign slt   = $signed(src_a) < $signed(src_b);
  // Branch comparison is its own subtractor so beq works whatever op decode selects.
  assign zero  = (diff == '0);

  always_comb begin
    alu_result = '0;
    case (ex.ALUControlE)
      3'b000:  alu_result = sum;
      3'b001:  alu_result = diff;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b100:  alu_result = src_a ^ src_b;
      3'b101:  alu_result = XLEN'(slt);
      3'b110:  alu_result = src_a << shamt;
      default: alu_result = src_a >> shamt;
    endcase
  end

  assign jalr_sum     = src_a + ex.Imm_Ext_E;
  assign ex.PCTargetE = ex.JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (ex.PCE + ex.Imm_Ext_E);
  assign ex.PCSrcE    = ex.ValidE & ((ex.BranchE & zero) | ex.JumpE);

  // EX/MEM register: reset beats flush beats stall; bubbles never carry write enables.
  always_ff @(posedge clk) begin
    if (rst || ex.FlushM) begin
      ex.RegWriteM   <= 1'b0;
      ex.MemWriteM   <= 1'b0;
      ex.ValidM      <= 1'b0;
      ex.ResultSrcM  <= 2'b00;
      ex.RD_M        <= REGW'(0);
      ex.ALU_ResultM <= XLEN'(0);
      ex.WriteDataM  <= XLEN'(0);
      ex.PCPlus4M    <= XLEN'(0);
    end else if (!ex.StallM) begin
      ex.RegWriteM   <= ex.RegWriteE & ex.ValidE;
      ex.MemWriteM   <= ex.MemWriteE & ex.ValidE;
      ex.ValidM      <= ex.ValidE;
      ex.ResultSrcM  <= ex.ResultSrcE;
      ex.RD_M        <= ex.RD_E;
      ex.ALU_ResultM <= alu_result;
      ex.WriteDataM  <= fwd_b;
      ex.PCPlus4M    <= ex.PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: stimulus queues hand-computed expectations,
// a monitor pops one per cycle and compares redirect and EX/MEM outputs.
module tb_execute_stage;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic        v;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
  } m_t;

  typedef struct {
    logic        chk_c;
    logic        pcsrc;
    logic        chk_t;
    logic [31:0] target;
    m_t          m;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  exp_t mon_e;
  int   n_vec;
  int   n_bad;

  execute_stage_if #(.XLEN(32), .REGW(5)) ex();

  execute_stage #(.XLEN(32), .REGW(5)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (ex)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic m_t mk(input logic rw, input logic mw, input logic v, input logic [1:0] rs,
                            input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                            input logic [31:0] pc4);
    m_t m;
    m.rw = rw; m.mw = mw; m.v = v; m.rs = rs; m.rd = rd;
    m.alu = alu; m.wd = wd; m.pc4 = pc4;
    return m;
  endfunction

  task automatic push(input logic chk_c, input logic pcsrc, input logic chk_t,
                      input logic [31:0] tgt, input m_t m);
    exp_t e;
    e.chk_c = chk_c; e.pcsrc = pcsrc; e.chk_t = chk_t; e.target = tgt; e.m = m;
    q.push_back(e);
  endtask

  task automatic clear_e();
    ex.StallM = 1'b0; ex.FlushM = 1'b0; ex.ValidE = 1'b0; ex.RegWriteE = 1'b0;
    ex.MemWriteE = 1'b0; ex.ResultSrcE = 2'b00; ex.BranchE = 1'b0; ex.JumpE = 1'b0;
    ex.JalrE = 1'b0; ex.ALUSrcE = 1'b0; ex.ALUControlE = 3'b000; ex.RD1_E = '0;
    ex.RD2_E = '0; ex.Imm_Ext_E = '0; ex.PCE = '0; ex.PCPlus4E = '0; ex.RD_E = '0;
    ex.ForwardAE = 2'b00; ex.ForwardBE = 2'b00; ex.ResultW = '0;
  endtask

  task automatic rand_e();
    ex.ValidE = 1'($urandom); ex.RegWriteE = 1'($urandom); ex.MemWriteE = 1'($urandom);
    ex.ResultSrcE = 2'($urandom); ex.BranchE = 1'($urandom); ex.JumpE = 1'($urandom);
    ex.JalrE = 1'($urandom); ex.ALUSrcE = 1'($urandom); ex.ALUControlE = 3'($urandom);
    ex.RD1_E = $urandom; ex.RD2_E = $urandom; ex.Imm_Ext_E = $urandom; ex.PCE = $urandom;
    ex.PCPlus4E = $urandom; ex.RD_E = 5'($urandom); ex.ForwardAE = 2'($urandom);
    ex.ForwardBE = 2'($urandom); ex.ResultW = $urandom;
  endtask

  // Monitor: redirect sampled before the edge, EX/MEM contents just after it.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        if (mon_e.chk_c) chk("PCSrcE", 32'(ex.PCSrcE), 32'(mon_e.pcsrc));
        if (mon_e.chk_t) chk("PCTargetE", ex.PCTargetE, mon_e.target);
        @(posedge clk);
        #1;
        chk("RegWriteM", 32'(ex.RegWriteM), 32'(mon_e.m.rw));
        chk("MemWriteM", 32'(ex.MemWriteM), 32'(mon_e.m.mw));
        chk("ValidM", 32'(ex.ValidM), 32'(mon_e.m.v));
        chk("ResultSrcM", 32'(ex.ResultSrcM), 32'(mon_e.m.rs));
        chk("RD_M", 32'(ex.RD_M), 32'(mon_e.m.rd));
        chk("ALU_ResultM", ex.ALU_ResultM, mon_e.m.alu);
        chk("WriteDataM", ex.WriteDataM, mon_e.m.wd);
        chk("PCPlus4M", ex.PCPlus4M, mon_e.m.pc4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    m_t em;
    int waited;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    clear_e();

    // Reset for two cycles with garbage on the E side
    repeat (2) begin
      @(negedge clk); rst = 1'b1; clear_e(); rand_e();
      push(1'b0, 1'b0, 1'b0, 32'h0, mk(0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0));
    end

    // add 5+7
    @(negedge clk); rst = 1'b0; clear_e();
    ex.ValidE = 1; ex.RegWriteE = 1; ex.RD1_E = 5; ex.RD2_E = 7; ex.RD_E = 1;
    ex.PCE = 32'hC; ex.PCPlus4E = 32'h10;
    em = mk(1, 0, 1, 2'b00, 5'd1, 32'd12, 32'd7, 32'h10);
    push(1'b1, 1'b0, 1'b1, 32'hC, em);

    // sub forwarding A from own ALU_ResultM: 12-2
    @(negedge clk); clear_e();
    ex.ValidE = 1; ex.RegWriteE = 1; ex.ALUControlE = 3'b001; ex.ForwardAE = 2'b10;
    ex.RD1_E = 0; ex.RD2_E = 2; ex.RD_E = 2; ex.PCPlus4E = 32'h14;
    em = mk(1, 0, 1, 2'b00, 5'd2, 32'd10, 32'd2, 32'h14);
    push(1'b0, 1'b0, 1'b0, 32'h0, em);

    // and with B forwarded from writeback: 0xF & 3
    @(negedge clk); clear_e();
    ex.ValidE = 1; ex.RegWriteE = 1; ex.ALUControlE = 3'b010; ex.ForwardBE = 2'b01;
    ex.ResultW = 3; ex.RD1_E = 32'hF; ex.RD2_E = 32'h55; ex.RD_E = 3; ex.PCPlus4E = 32'h18;
    em = mk(1, 0, 1, 2'b00, 5'd3, 32'd3, 32'd3, 32'h18);
    push(1'b0, 1'b0, 1'b0, 32'h0, em);

    // beq taken, ALU doing or to show Zero ignores op decode
    @(negedge clk); clear_e();
    ex.ValidE = 1; ex.BranchE = 1; ex.ALUControlE = 3'b011; ex.RD1_E = 32'h40;
    ex.RD2_E = 32'h40; ex.PCE = 32'h100; ex.Imm_Ext_E = 32'h20; ex.PCPlus4E = 32'h104;
    em = mk(0, 0, 1, 2'b00, 5'd0, 32'h40, 32'h40, 32'h104);
    push(1'b1, 1'b1, 1'b1, 32'h120, em);

    // same beq as a bubble with stale write enables
    @(negedge clk); clear_e();
    ex.ValidE = 0; ex.BranchE = 1; ex.RegWriteE = 1; ex.MemWriteE = 1; ex.ALUControlE = 3'b011;
    ex.RD1_E = 32'h40; ex.RD2_E = 32'h40; ex.PCE = 32'h100; ex.Imm_Ext_E = 32'h20;
    ex.PCPlus4E = 32'h104; ex.RD_E = 5;
    em = mk(0, 0, 0, 2'b00, 5'd5, 32'h40, 32'h40, 32'h104);
    push(1'b1, 1'b0, 1'b1, 32'h120, em);

    // jalr 0x203+4 -> target 0x206
    @(negedge clk); clear_e();
    ex.ValidE = 1; ex.JumpE = 1; ex.JalrE = 1; ex.RegWriteE = 1; ex.ResultSrcE = 2'b10;
    ex.ALUSrcE = 1; ex.RD1_E = 32'h203; ex.RD2_E = 32'h99; ex.Imm_Ext_E = 4;
    ex.PCE = 32'h300; ex.PCPlus4E = 32'h304; ex.RD_E = 1;
    em = mk(1, 0, 1, 2'b10, 5'd1, 32'h207, 32'h99, 32'h304);
    push(1'b1, 1'b1, 1'b1, 32'h206, em);

    // stall 3 cycles; jalr off the held ALU_ResultM (0x207+1 -> 0x208)
    @(negedge clk); clear_e();
    ex.StallM = 1; ex.ValidE = 1; ex.JumpE = 1; ex.JalrE = 1; ex.ForwardAE = 2'b10;
    ex.ALUSrcE = 1; ex.Imm_Ext_E = 1; ex.RegWriteE = 1; ex.RD_E = 9; ex.PCPlus4E = 32'h777;
    push(1'b1, 1'b1, 1'b1, 32'h208, em);

    @(negedge clk); clear_e();
    ex.StallM = 1; ex.ValidE = 1; ex.BranchE = 1; ex.MemWriteE = 1; ex.RD1_E = 7;
    ex.RD2_E = 7; ex.PCE = 32'h400; ex.Imm_Ext_E = 32'h10; ex.RD_E = 11;
    push(1'b1, 1'b1, 1'b1, 32'h410, em);

    @(negedge clk); clear_e(); rand_e();
    ex.StallM = 1;
    push(1'b0, 1'b0, 1'b0, 32'h0, em);

    // flush wins over stall
    @(negedge clk); clear_e();
    ex.StallM = 1; ex.FlushM = 1; ex.ValidE = 1; ex.RegWriteE = 1; ex.MemWriteE = 1;
    ex.RD1_E = 32'h1234; ex.RD_E = 7; ex.PCPlus4E = 32'h50;
    em = mk(0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    push(1'b0, 1'b0, 1'b0, 32'h0, em);

    // ALU corners: wrap add
    @(negedge clk); clear_e();
    ex.ValidE = 1; ex.RegWriteE = 1; ex.ALUSrcE = 1; ex.RD1_E = 32'h7FFF_FFFF;
    ex.Imm_Ext_E = 1; ex.PCE = 32'h500; ex.PCPlus4E = 32'h504; ex.RD_E = 4;
    em = mk(1, 0, 1, 2'b00, 5'd4, 32'h8000_0000, 32'h0, 32'h504);
    push(1'b1, 1'b0, 1'b1, 32'h501, em);

    // signed slt -1 < 1, as a store
    @(negedge clk); clear_e();
    ex.ValidE = 1; ex.MemWriteE = 1; ex.ALUControlE = 3'b101; ex.RD1_E = 32'hFFFF_FFFF;
    ex.RD2_E = 1; ex.RD_E = 4; ex.PCPlus4E = 32'h508;
    em = mk(0, 1, 1, 2'b00, 5'd4, 32'd1, 32'd1, 32'h508);
    push(1'b0, 1'b0, 1'b0, 32'h0, em);

    // sll 1 by 33 uses low 5 bits
    @(negedge clk); clear_e();
    ex.ValidE = 1; ex.RegWriteE = 1; ex.ALUControlE = 3'b110; ex.ALUSrcE = 1;
    ex.RD1_E = 1; ex.Imm_Ext_E = 33; ex.RD2_E = 32'h12; ex.RD_E = 6; ex.PCPlus4E = 32'h50C;
    em = mk(1, 0, 1, 2'b00, 5'd6, 32'd2, 32'h12, 32'h50C);
    push(1'b0, 1'b0, 1'b0, 32'h0, em);

    // srl is logical
    @(negedge clk); clear_e();
    ex.ValidE = 1; ex.RegWriteE = 1; ex.ALUControlE = 3'b111; ex.RD1_E = 32'h8000_0000;
    ex.RD2_E = 31; ex.RD_E = 7; ex.PCPlus4E = 32'h510;
    em = mk(1, 0, 1, 2'b00, 5'd7, 32'd1, 32'd31, 32'h510);
    push(1'b0, 1'b0, 1'b0, 32'h0, em);

    // xor
    @(negedge clk); clear_e();
    ex.ValidE = 1; ex.RegWriteE = 1; ex.ALUControlE = 3'b100; ex.RD1_E = 32'hF0F0;
    ex.RD2_E = 32'hFF00; ex.RD_E = 8; ex.ResultSrcE = 2'b01; ex.PCPlus4E = 32'h514;
    em = mk(1, 0, 1, 2'b01, 5'd8, 32'h0FF0, 32'hFF00, 32'h514);
    push(1'b0, 1'b0, 1'b0, 32'h0, em);

    // ForwardA/B = 11 behaves as 00
    @(negedge clk); clear_e();
    ex.ValidE = 1; ex.RegWriteE = 1; ex.ForwardAE = 2'b11; ex.ForwardBE = 2'b11;
    ex.RD1_E = 32'h10; ex.RD2_E = 1; ex.ResultW = 32'h999; ex.RD_E = 9; ex.PCPlus4E = 32'h518;
    em = mk(1, 0, 1, 2'b00, 5'd9, 32'h11, 32'h1, 32'h518);
    push(1'b0, 1'b0, 1'b0, 32'h0, em);

    // reset mid-stream beats stall and flush
    @(negedge clk); clear_e();
    rst = 1; ex.StallM = 1; ex.FlushM = 1; ex.ValidE = 1; ex.RegWriteE = 1; ex.RD1_E = 3;
    em = mk(0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    push(1'b0, 1'b0, 1'b0, 32'h0, em);

    // resume after reset
    @(negedge clk); rst = 0; clear_e();
    ex.ValidE = 1; ex.RegWriteE = 1; ex.RD1_E = 2; ex.RD2_E = 3; ex.RD_E = 10;
    ex.PCPlus4E = 32'h600;
    em = mk(1, 0, 1, 2'b00, 5'd10, 32'd5, 32'd3, 32'h600);
    push(1'b0, 1'b0, 1'b0, 32'h0, em);

    // idle bubble
    @(negedge clk); clear_e();
    em = mk(0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    push(1'b1, 1'b0, 1'b0, 32'h0, em);

    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
